kf_fx_mac_seq: RTL and testbench
================================

Name: kf_fx_mac_seq

Overview:
- Sequenced fixed-point multiply-accumulate engine for the Kalman-filter datapath.
- Computes out = a*b*c ± d, or a*b + d, using one shared multiplier and one adder, driven by an explicit FSM.
- Parametrised successor of the scalar 32-bit integer a*b*c+d sequencer: adds configurable width, fractional bits, saturation, op modes, overflow flag and valid/ready handshakes on both sides.
- Sits between the covariance/gain register file and the state-update stage.

Parameters:
WIDTH, 32, operand/result width; signed two's complement.
FRAC, 0, fractional bits (Q format); every product is arithmetic-shifted right by FRAC.
SAT, 1, 1 = saturate on overflow, 0 = wrap (two's-complement truncation).

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  operand set valid
in_ready  out  1  block can accept operands
a  in  WIDTH  multiplicand 1
b  in  WIDTH  multiplicand 2
c  in  WIDTH  multiplicand 3 (ignored in mode 01)
d  in  WIDTH  addend/subtrahend
mode  in  2  00: a*b*c+d; 01: a*b+d; 10: a*b*c-d; 11: reserved, treated as 00
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out  out  WIDTH  result
ovf  out  1  overflow/saturation occurred in any stage of this operation; valid with out_valid

Behaviour:
- Reset (rst=1 at a clock edge):
  - state←IDLE; out=0, ovf=0, out_valid=0; internal operand registers cleared.
  - Reset mid-operation abandons the operation; no result is emitted.
- FSM states: IDLE, MUL1, MUL2, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture a, b, c, d, mode → MUL1.
  - in_ready=0 in every other state; one operation in flight.
- MUL1: p←fx_mul(a,b).
  - Mode 01 → ADD.
  - All other modes → MUL2.
- MUL2: p←fx_mul(p,c) → ADD.
- ADD: out←sat(p+d) (modes 00/11) or sat(p−d) (mode 10) → DONE.
- DONE:
  - out_valid=1; out and ovf held stable while out_ready=0.
  - On out_ready=1: out_valid falls next cycle → IDLE.
  - out keeps its last value until the next ADD.
- Latency from accept edge to out_valid high:
  - 4 cycles for modes 00/10/11.
  - 3 cycles for mode 01.
- Throughput: one op per latency+1 cycles minimum; no accept while in DONE.
- fx_mul:
  - Full 2*WIDTH signed product.
  - Arithmetic shift right by FRAC (truncate toward −inf).
  - Reduce to WIDTH: if SAT, clamp to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; else keep low WIDTH bits.
  - Either way, set the overflow indication if the value did not fit.
- Add/sub:
  - Computed at WIDTH+1 bits, then the same clamp/wrap rule.
- ovf:
  - OR of all stage overflow indications for the current op.
  - Cleared at accept.
- in_valid while in_ready=0: ignored; the upstream source must hold it.
- Simultaneous out_ready and rst: reset wins.

Decomposition:
- Package kf_fx_pkg:
  - state enum.
  - mode encoding constants (MODE_ABCPD=2'b00, MODE_ABPD=2'b01, MODE_ABCMD=2'b10).
  - saturate/clamp function parameterised by WIDTH.
- Sub-module kf_fx_mul:
  - Combinational.
  - Signed WIDTH×WIDTH multiply, FRAC shift, SAT clamp/wrap, ovf output.
  - Instantiated once and shared by MUL1 and MUL2 through an operand mux.

Test Plan:
1. WIDTH=32, FRAC=0, SAT=1, mode 00, a=2, b=3, c=4, d=5 → out=29, ovf=0, out_valid exactly 4 cycles after accept; mode 10, same operands → out=19.
2. Mode 01, a=−7, b=6, c=99, d=10 → out=−32, out_valid 3 cycles after accept, c ignored.
3. Saturation, mode 00, a=0x40000000, b=4, c=1, d=0:
   - SAT=1 → out=0x7FFFFFFF, ovf=1.
   - SAT=0 → out=0x00000000, ovf=1.
   - Negative variant a=0xC0000000, b=4, SAT=1 → out=0x80000000.
4. FRAC=16, mode 00, a=0x18000 (1.5), b=0x20000 (2.0), c=0x10000 (1.0), d=0x4000 (0.25) → out=0x34000 (3.25), ovf=0.
5. Backpressure: hold out_ready=0 for 3 cycles in DONE → out/ovf/out_valid stable, in_ready=0, a new in_valid is not accepted; release → in_ready=1 one cycle later.
6. Assert rst during MUL2 → next cycle out_valid=0, out=0, in_ready=1; a subsequent op completes correctly.

Source files
------------

// File: rtl/kf_fx_pkg.sv
// kf_fx_pkg: shared FSM states, mode codes and the clamp/wrap reduction helper
package kf_fx_pkg;
  typedef enum logic [2:0] {IDLE, MUL1, MUL2, ADD, DONE} state_e;
  localparam logic [1:0] MODE_ABCPD = 2'b00;
  localparam logic [1:0] MODE_ABPD = 2'b01;
  localparam logic [1:0] MODE_ABCMD = 2'b10;
  localparam int MAX_W = 64;
  localparam int EXT_W = 2 * MAX_W + 1;
  typedef struct packed {
    logic ovf;
    logic [EXT_W-1:0] val;
  } red_t;
  function automatic red_t reduce(input logic signed [EXT_W-1:0] v, input int w, input logic sat);
    logic signed [EXT_W-1:0] hi;
    red_t r;
    hi = v >>> (w - 1);
    r.ovf = !((hi == '0) || (hi == '1));
    r.val = v;
    if (sat && r.ovf)
      r.val = v[EXT_W-1] ? {EXT_W{1'b1}} << (w - 1) : ({{(EXT_W-1){1'b0}}, 1'b1} << (w - 1)) - 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/kf_fx_mac_seq_if.sv
// kf_fx_mac_seq_if: operand/result handshake bundle of the MAC sequencer
interface kf_fx_mac_seq_if #(parameter int WIDTH = 32);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [1:0] mode;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out;
  logic ovf;
  modport master(output in_valid, a, b, c, d, mode, out_ready, input in_ready, out_valid, out, ovf);
  modport slave(input in_valid, a, b, c, d, mode, out_ready, output in_ready, out_valid, out, ovf);
endinterface

// File: rtl/kf_fx_mul.sv
// kf_fx_mul: combinational signed fixed-point multiply with Q shift and saturate/wrap
module kf_fx_mul import kf_fx_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int FRAC = 0,
  parameter int SAT = 1
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  output logic [WIDTH-1:0] p,
  output logic ovf
);
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] sh;
  red_t r;
  logic unused_hi;
  always_comb begin
    prod = x * y;
    sh = prod >>> FRAC;
    r = reduce({{(EXT_W-2*WIDTH){sh[2*WIDTH-1]}}, sh}, WIDTH, SAT != 0);
  end
  assign p = r.val[WIDTH-1:0];
  assign ovf = r.ovf;
  assign unused_hi = ^r.val[EXT_W-1:WIDTH];
endmodule

// File: rtl/kf_fx_mac_seq.sv
// kf_fx_mac_seq: sequenced fixed-point a*b*c+-d / a*b+d engine with one shared multiplier
module kf_fx_mac_seq import kf_fx_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int FRAC = 0,
  parameter int SAT = 1
) (
  input logic clk,
  input logic rst,
  kf_fx_mac_seq_if.slave bus
);
  state_e state_q;
  logic [WIDTH-1:0] a_q, b_q, c_q, d_q, p_q, out_q;
  logic [1:0] mode_q;
  logic ovf_q, in_ready_q, out_valid_q;
  logic [WIDTH-1:0] mul_x_d, mul_y_d, mul_p_d, add_d;
  logic mul_ovf_d, add_ovf_d;
  logic signed [WIDTH:0] sum_d;
  red_t add_r;
  logic unused_add;
  always_comb begin
    mul_x_d = (state_q == MUL1) ? a_q : p_q;
    mul_y_d = (state_q == MUL1) ? b_q : c_q;
    sum_d = (mode_q == MODE_ABCMD) ? $signed({p_q[WIDTH-1], p_q}) - $signed({d_q[WIDTH-1], d_q})
                                   : $signed({p_q[WIDTH-1], p_q}) + $signed({d_q[WIDTH-1], d_q});
    add_r = reduce({{(EXT_W-WIDTH-1){sum_d[WIDTH]}}, sum_d}, WIDTH, SAT != 0);
    add_d = add_r.val[WIDTH-1:0];
    add_ovf_d = add_r.ovf;
  end
  assign unused_add = ^add_r.val[EXT_W-1:WIDTH];
  kf_fx_mul #(.WIDTH(WIDTH), .FRAC(FRAC), .SAT(SAT)) u_mul (
    .x(mul_x_d),
    .y(mul_y_d),
    .p(mul_p_d),
    .ovf(mul_ovf_d)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
      p_q <= '0;
      mode_q <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_q <= bus.a;
          b_q <= bus.b;
          c_q <= bus.c;
          d_q <= bus.d;
          mode_q <= bus.mode;
          ovf_q <= 1'b0;
          in_ready_q <= 1'b0;
          state_q <= MUL1;
        end
        MUL1: begin
          p_q <= mul_p_d;
          ovf_q <= ovf_q | mul_ovf_d;
          state_q <= (mode_q == MODE_ABPD) ? ADD : MUL2;
        end
        MUL2: begin
          p_q <= mul_p_d;
          ovf_q <= ovf_q | mul_ovf_d;
          state_q <= ADD;
        end
        ADD: begin
          out_q <= add_d;
          ovf_q <= ovf_q | add_ovf_d;
          out_valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out = out_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_kf_fx_mac_seq.sv
// tb_kf_fx_mac_seq: scoreboarded directed test of three MAC configurations
module tb_kf_fx_mac_seq;
  typedef struct {
    logic [31:0] o;
    logic v;
    int lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] in_valid = '0;
  logic [31:0] a = '0, b = '0, c = '0, d = '0;
  logic [1:0] mode = '0;
  logic out_ready = 1'b1;
  logic [2:0] in_ready_v, out_valid_v, ovf_v;
  logic [31:0] out_v [3];
  exp_t q [3][$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : u
    kf_fx_mac_seq_if #(.WIDTH(32)) bus ();
    kf_fx_mac_seq #(.WIDTH(32), .FRAC(g == 2 ? 16 : 0), .SAT(g == 1 ? 0 : 1)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
    assign bus.in_valid = in_valid[g];
    assign bus.a = a;
    assign bus.b = b;
    assign bus.c = c;
    assign bus.d = d;
    assign bus.mode = mode;
    assign bus.out_ready = out_ready;
    assign in_ready_v[g] = bus.in_ready;
    assign out_valid_v[g] = bus.out_valid;
    assign ovf_v[g] = bus.ovf;
    assign out_v[g] = bus.out;
    int acc = 0;
    bit seen = 1'b0;
    exp_t e;
    always @(negedge clk) begin
      if (rst) seen = 1'b0;
      else begin
        if (bus.in_valid && bus.in_ready) acc = cyc;
        if (bus.out_valid && !seen) begin
          seen = 1'b1;
          if (q[g].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL dut%0d_unexpected_out: got %h expected no result", g, bus.out);
          end else begin
            e = q[g].pop_front();
            chk($sformatf("dut%0d_out", g), bus.out, e.o);
            chk($sformatf("dut%0d_ovf", g), {31'd0, bus.ovf}, {31'd0, e.v});
            chk($sformatf("dut%0d_latency", g), cyc - acc, e.lat);
          end
        end
        if (bus.out_valid && bus.out_ready) seen = 1'b0;
      end
    end
  end
  task automatic issue(input int s, input logic [1:0] m, input logic [31:0] av, bv, cv, dv,
                       input logic [31:0] eo, input logic ev, input int lat, input bit push);
    bit ok = 1'b0;
    a = av;
    b = bv;
    c = cv;
    d = dv;
    mode = m;
    in_valid[s] = 1'b1;
    if (push) q[s].push_back('{eo, ev, lat});
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready_v[s]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk($sformatf("dut%0d_accept_timeout", s), 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid[s] = 1'b0;
  endtask
  task automatic wait_out(input int s);
    bit ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid_v[s]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk($sformatf("dut%0d_result_timeout", s), 32'd0, 32'd1);
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic op(input int s, input logic [1:0] m, input logic [31:0] av, bv, cv, dv,
                    input logic [31:0] eo, input logic ev, input int lat);
    issue(s, m, av, bv, cv, dv, eo, ev, lat, 1'b1);
    wait_out(s);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid_v[0]}, 32'd0);
    chk("rst_out", out_v[0], 32'd0);
    chk("rst_ovf", {31'd0, ovf_v[0]}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready_v[0]}, 32'd1);
    @(posedge clk);
    #1;
    op(0, 2'b00, 32'd2, 32'd3, 32'd4, 32'd5, 32'd29, 1'b0, 4);
    op(0, 2'b10, 32'd2, 32'd3, 32'd4, 32'd5, 32'd19, 1'b0, 4);
    op(0, 2'b01, -32'sd7, 32'd6, 32'd99, 32'd10, 32'hFFFF_FFE0, 1'b0, 3);
    op(0, 2'b00, 32'h4000_0000, 32'd4, 32'd1, 32'd0, 32'h7FFF_FFFF, 1'b1, 4);
    op(0, 2'b00, 32'hC000_0000, 32'd4, 32'd1, 32'd0, 32'h8000_0000, 1'b1, 4);
    op(0, 2'b11, 32'd2, 32'd3, 32'd4, 32'd5, 32'd29, 1'b0, 4);
    op(0, 2'b00, 32'd1, 32'd1, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 1'b1, 4);
    op(0, 2'b10, 32'd1, 32'd1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b1, 4);
    op(1, 2'b00, 32'h4000_0000, 32'd4, 32'd1, 32'd0, 32'h0000_0000, 1'b1, 4);
    op(1, 2'b00, 32'd1, 32'd1, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, 4);
    op(2, 2'b00, 32'h0001_8000, 32'h0002_0000, 32'h0001_0000, 32'h0000_4000, 32'h0003_4000, 1'b0, 4);
    op(2, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'h0001_0000, 32'd0, 32'hFFFF_FFFF, 1'b0, 4);
    out_ready = 1'b0;
    issue(0, 2'b00, 32'd2, 32'd3, 32'd4, 32'd5, 32'd29, 1'b0, 4, 1'b1);
    wait_out(0);
    a = 32'd7;
    mode = 2'b01;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out", out_v[0], 32'd29);
      chk("bp_ovf", {31'd0, ovf_v[0]}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid_v[0]}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready_v[0]}, 32'd0);
    end
    in_valid[0] = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'd0, in_ready_v[0]}, 32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid_v[0]}, 32'd0);
    @(posedge clk);
    #1;
    issue(0, 2'b00, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid_v[0]}, 32'd0);
    chk("midrst_out", out_v[0], 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready_v[0]}, 32'd1);
    repeat (6) @(negedge clk);
    chk("midrst_no_emit", {31'd0, out_valid_v[0]}, 32'd0);
    @(posedge clk);
    #1;
    op(0, 2'b10, 32'd2, 32'd3, 32'd4, 32'd5, 32'd19, 1'b0, 4);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) chk($sformatf("dut%0d_queue_drained", s), q[s].size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
